// File: rtl/mem_bist_collar.sv
// BIST collar around a DEPTH x 8 array: muxes mission/BIST access and pipelines read-compare results.
// Define MEM_BIST_COLLAR_ERRCNT_EN to build the mismatch counter; otherwise bistErrCnt_o is tied to 0.
module mem_bist_collar #(
  parameter int DEPTH         = 32,
  parameter bit FAIL_SATURATE = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       bistEn_i,
  input  logic [7:0] bistAddr_i,
  input  logic [7:0] bistWrData_i,
  input  logic       bistWrEn_i,
  output logic       bistRdData_o,
  output logic       bistRdValid_o,
  output logic       bistFail_o,
  output logic [7:0] bistFailAddr_o,
  output logic [7:0] bistErrCnt_o,
  output logic       bistBusy_o,
  input  logic [7:0] funcAddr_i,
  input  logic [7:0] funcWrData_i,
  input  logic       funcWrEn_i,
  output logic [7:0] funcRdData_o
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {IDLE, ACTIVE, DRAIN} state_e;

  state_e     state_q, state_d;
  logic       drainCnt_q, drainCnt_d;

  logic [7:0] mem [0:DEPTH-1];
  logic       memWe;
  logic [7:0] memWrAddr, memWrData;
  logic       bistRdIssue, startRun;

  logic       s1Valid_q, s1InRange_q;
  logic [7:0] s1Data_q, s1Exp_q, s1Addr_q;
  logic       rdValid_q, rdData_q;
  logic       fail_q, fail_d;
  logic [7:0] failAddr_q, failAddr_d;
  logic [7:0] funcRd_q, funcRd_d;
  logic       mismatch;

  function automatic logic inRange(input logic [7:0] a);
    return ({1'b0, a} < DEPTH[8:0]);
  endfunction

  function automatic logic [7:0] errCntNext(input logic [7:0] c);
    if (c == 8'hFF) return FAIL_SATURATE ? 8'hFF : 8'h00;
    return c + 8'd1;
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      drainCnt_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      drainCnt_q <= drainCnt_d;
    end
  end

  // DRAIN is held for exactly two cycles so the two-stage compare pipeline empties.
  always_comb begin
    state_d    = state_q;
    drainCnt_d = drainCnt_q;
    case (state_q)
      IDLE: begin
        if (bistEn_i) state_d = ACTIVE;
      end
      ACTIVE: begin
        if (!bistEn_i) begin
          state_d    = DRAIN;
          drainCnt_d = 1'b0;
        end
      end
      DRAIN: begin
        if (bistEn_i)        state_d = ACTIVE;
        else if (drainCnt_q) state_d = IDLE;
        else                 drainCnt_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bistBusy_o  = (state_q != IDLE);
    startRun    = (state_q == IDLE) && bistEn_i;
    bistRdIssue = (state_q == ACTIVE) && bistEn_i && !bistWrEn_i;
    memWe       = 1'b0;
    memWrAddr   = funcAddr_i;
    memWrData   = funcWrData_i;
    if (state_q == IDLE) begin
      memWe = funcWrEn_i && inRange(funcAddr_i);
    end else if (state_q == ACTIVE) begin
      memWe     = bistEn_i && bistWrEn_i && inRange(bistAddr_i);
      memWrAddr = bistAddr_i;
      memWrData = bistWrData_i;
    end
  end

  // Array contents survive reset.
  always_ff @(posedge clk) begin
    if (memWe) mem[memWrAddr[IW-1:0]] <= memWrData;
  end

  assign mismatch = s1Valid_q && s1InRange_q && (s1Data_q != s1Exp_q);

  always_comb begin
    fail_d     = fail_q;
    failAddr_d = failAddr_q;
    if (startRun) begin
      fail_d     = 1'b0;
      failAddr_d = 8'h00;
    end else if (mismatch) begin
      fail_d = 1'b1;
      if (!fail_q) failAddr_d = s1Addr_q;
    end
    funcRd_d = 8'h00;
    if ((state_d == IDLE) && inRange(funcAddr_i)) funcRd_d = mem[funcAddr_i[IW-1:0]];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1Valid_q   <= 1'b0;
      s1InRange_q <= 1'b0;
      s1Data_q    <= 8'h00;
      s1Exp_q     <= 8'h00;
      s1Addr_q    <= 8'h00;
      rdValid_q   <= 1'b0;
      rdData_q    <= 1'b0;
      fail_q      <= 1'b0;
      failAddr_q  <= 8'h00;
      funcRd_q    <= 8'h00;
    end else begin
      s1Valid_q   <= bistRdIssue;
      s1InRange_q <= inRange(bistAddr_i);
      s1Data_q    <= inRange(bistAddr_i) ? mem[bistAddr_i[IW-1:0]] : 8'h00;
      s1Exp_q     <= bistWrData_i;
      s1Addr_q    <= bistAddr_i;
      rdValid_q   <= s1Valid_q;
      rdData_q    <= mismatch;
      fail_q      <= fail_d;
      failAddr_q  <= failAddr_d;
      funcRd_q    <= funcRd_d;
    end
  end

`ifdef MEM_BIST_COLLAR_ERRCNT_EN
  logic [7:0] errCnt_q, errCnt_d;

  always_comb begin
    errCnt_d = errCnt_q;
    if (startRun)      errCnt_d = 8'h00;
    else if (mismatch) errCnt_d = errCntNext(errCnt_q);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) errCnt_q <= 8'h00;
    else        errCnt_q <= errCnt_d;
  end

  assign bistErrCnt_o = errCnt_q;
`else
  assign bistErrCnt_o = 8'h00;
`endif

  assign bistRdValid_o  = rdValid_q;
  assign bistRdData_o   = rdData_q;
  assign bistFail_o     = fail_q;
  assign bistFailAddr_o = failAddr_q;
  assign funcRdData_o   = funcRd_q;

endmodule

// File: tb/tb_mem_bist_collar.sv
// Scoreboard bench for mem_bist_collar: read-compare results are predicted from a shadow array
// and checked, with their latency, as bistRdValid_o pulses.
module tb_mem_bist_collar;

  localparam int DEPTH = 32;
  localparam bit SAT   = 1'b1;

  logic       clk = 1'b0;
  logic       reset;
  logic       bistEn_i, bistWrEn_i, funcWrEn_i;
  logic [7:0] bistAddr_i, bistWrData_i, funcAddr_i, funcWrData_i;
  logic       bistRdData_o, bistRdValid_o, bistFail_o, bistBusy_o;
  logic [7:0] bistFailAddr_o, bistErrCnt_o, funcRdData_o;

  typedef struct {
    logic exp;
    int   issue;
  } rd_t;

  rd_t        sb[$];
  rd_t        monR;
  logic [7:0] model [0:255];
  int         vecCnt = 0;
  int         missCnt = 0;
  int         cyc = 0;

  mem_bist_collar #(.DEPTH(DEPTH), .FAIL_SATURATE(SAT)) dut (
    .clk(clk), .reset(reset),
    .bistEn_i(bistEn_i), .bistAddr_i(bistAddr_i), .bistWrData_i(bistWrData_i),
    .bistWrEn_i(bistWrEn_i), .bistRdData_o(bistRdData_o), .bistRdValid_o(bistRdValid_o),
    .bistFail_o(bistFail_o), .bistFailAddr_o(bistFailAddr_o), .bistErrCnt_o(bistErrCnt_o),
    .bistBusy_o(bistBusy_o), .funcAddr_i(funcAddr_i), .funcWrData_i(funcWrData_i),
    .funcWrEn_i(funcWrEn_i), .funcRdData_o(funcRdData_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] expCnt(input int n);
`ifdef MEM_BIST_COLLAR_ERRCNT_EN
    if (n > 255) return SAT ? 8'hFF : 8'(n % 256);
    return 8'(n);
`else
    return (n < 0) ? 8'h01 : 8'h00;
`endif
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecCnt++;
    if (obs !== exp) begin
      missCnt++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic en, input logic wr, input logic [7:0] addr,
                               input logic [7:0] data, input logic fWr,
                               input logic [7:0] fAddr, input logic [7:0] fData);
    rd_t r;
    bistEn_i     = en;
    bistWrEn_i   = wr;
    bistAddr_i   = addr;
    bistWrData_i = data;
    funcWrEn_i   = fWr;
    funcAddr_i   = fAddr;
    funcWrData_i = fData;
    if (en && !wr) begin
      r.exp   = (int'(addr) < DEPTH) ? (model[addr] != data) : 1'b0;
      r.issue = cyc;
      sb.push_back(r);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic bistIdle(input logic en);
    applyStimulus(en, 1'b1, 8'hFF, 8'h00, 1'b0, 8'h00, 8'h00);
  endtask

  task automatic bistWrite(input logic [7:0] addr, input logic [7:0] data);
    applyStimulus(1'b1, 1'b1, addr, data, 1'b0, 8'h00, 8'h00);
    if (int'(addr) < DEPTH) model[addr] = data;
  endtask

  task automatic bistRead(input logic [7:0] addr, input logic [7:0] exp);
    applyStimulus(1'b1, 1'b0, addr, exp, 1'b0, 8'h00, 8'h00);
  endtask

  task automatic funcWrite(input logic [7:0] addr, input logic [7:0] data);
    applyStimulus(1'b0, 1'b1, 8'hFF, 8'h00, 1'b1, addr, data);
    if (int'(addr) < DEPTH) model[addr] = data;
  endtask

  task automatic funcRead(input logic [7:0] addr);
    applyStimulus(1'b0, 1'b1, 8'hFF, 8'h00, 1'b0, addr, 8'h00);
  endtask

  task automatic checkResults(input string tag, input logic fail, input logic [7:0] addr, input int n);
    checkOutput({tag, "_fail"}, bistFail_o, fail);
    checkOutput({tag, "_failAddr"}, bistFailAddr_o, addr);
    checkOutput({tag, "_errCnt"}, bistErrCnt_o, expCnt(n));
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_rdData"}, bistRdData_o, 0);
    checkOutput({tag, "_rdValid"}, bistRdValid_o, 0);
    checkOutput({tag, "_busy"}, bistBusy_o, 0);
    checkOutput({tag, "_funcRd"}, funcRdData_o, 0);
    checkResults(tag, 1'b0, 8'h00, 0);
  endtask

  // Compare every valid read result against the oldest prediction.
  always @(negedge clk) begin
    if (reset) begin
      if (bistRdValid_o) begin
        if (sb.size() == 0) begin
          checkOutput("unexpectedValid", 1, 0);
        end else begin
          monR = sb.pop_front();
          checkOutput("rdMismatch", bistRdData_o, monR.exp);
          checkOutput("rdLatency", cyc - monR.issue, 2);
        end
      end else begin
        checkOutput("rdDataIdle", bistRdData_o, 0);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bistEn_i = 0; bistWrEn_i = 0; bistAddr_i = 0; bistWrData_i = 0;
    funcWrEn_i = 0; funcAddr_i = 0; funcWrData_i = 0;
    reset = 1'b1;
    #2 reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkAllZero("reset");
    reset = 1'b1;

    // Mission-mode access and registered read-before-write behaviour.
    funcWrite(8'd2, 8'h3C);
    funcRead(8'd2);
    checkOutput("funcRd2", funcRdData_o, 8'h3C);
    funcWrite(8'd2, 8'h77);
    checkOutput("funcRdOld", funcRdData_o, 8'h3C);
    funcRead(8'd2);
    checkOutput("funcRdNew", funcRdData_o, 8'h77);
    funcWrite(8'd40, 8'h99);
    funcRead(8'd40);
    checkOutput("funcRdOor", funcRdData_o, 8'h00);

    bistIdle(1'b1);
    checkOutput("busyActive", bistBusy_o, 1);
    checkOutput("funcRdActive", funcRdData_o, 8'h00);
    checkResults("entry", 1'b0, 8'h00, 0);

    bistWrite(8'd5, 8'hAA);
    bistWrite(8'd7, 8'h12);
    bistRead(8'd5, 8'hAA);
    bistRead(8'd2, 8'h77);
    applyStimulus(1'b1, 1'b1, 8'hFF, 8'h00, 1'b1, 8'd5, 8'h11);
    checkOutput("funcRdDuringBist", funcRdData_o, 8'h00);
    bistRead(8'd5, 8'hAA);
    repeat (3) bistIdle(1'b1);
    checkResults("pass", 1'b0, 8'h00, 0);

    bistRead(8'd5, 8'h55);
    bistRead(8'd7, 8'h34);
    bistWrite(8'd32, 8'h99);
    bistRead(8'd32, 8'h99);
    bistRead(8'd32, 8'h00);
    repeat (3) bistIdle(1'b1);
    checkResults("capture", 1'b1, 8'h05, 2);

    // Read completes in DRAIN, then re-entry from DRAIN keeps results.
    bistRead(8'd5, 8'h00);
    bistIdle(1'b0);
    checkOutput("busyDrain", bistBusy_o, 1);
    bistIdle(1'b1);
    checkOutput("busyReentry", bistBusy_o, 1);
    checkResults("reentryDrain", 1'b1, 8'h05, 3);

    bistIdle(1'b0);
    checkOutput("busyDrain1", bistBusy_o, 1);
    bistIdle(1'b0);
    checkOutput("busyDrain2", bistBusy_o, 1);
    bistIdle(1'b0);
    checkOutput("busyIdle", bistBusy_o, 0);
    checkResults("kept", 1'b1, 8'h05, 3);

    bistIdle(1'b1);
    checkResults("reentryIdle", 1'b0, 8'h00, 0);

    for (int i = 0; i < 300; i++) bistRead(8'd5, 8'h00);
    repeat (3) bistIdle(1'b0);
    checkOutput("busyAfterSat", bistBusy_o, 0);
    checkResults("saturate", 1'b1, 8'h05, 300);

    // Reset lands while a read is in flight.
    bistIdle(1'b1);
    bistRead(8'd5, 8'hAA);
    bistEn_i = 1'b0;
    reset = 1'b0;
    sb.delete();
    #2;
    checkAllZero("midReset");
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (4) bistIdle(1'b0);
    checkAllZero("postReset");
    funcRead(8'd2);
    checkOutput("memKept", funcRdData_o, 8'h77);

    checkOutput("sbEmpty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vecCnt, missCnt);
    $finish;
  end

endmodule
